// File: rtl/axil_pkg.sv
// Shared types, response codes, FSM state encodings and the address-to-index
// helper used by the AXI4-Lite register bridge.
package axil_pkg;

    typedef logic [1:0] axil_resp_t;

    localparam axil_resp_t RESP_OKAY   = 2'b00;
    localparam axil_resp_t RESP_SLVERR = 2'b10;

    typedef enum logic [2:0] {
        WR_IDLE   = 3'd0,
        WR_GOT_AW = 3'd1,
        WR_GOT_W  = 3'd2,
        WR_EXEC   = 3'd3,
        WR_RESP   = 3'd4
    } wr_state_t;

    typedef enum logic [1:0] {
        RD_IDLE = 2'd0,
        RD_EXEC = 2'd1,
        RD_RESP = 2'd2
    } rd_state_t;

    // Word index: drop the byte-lane bits, keep idx_w bits above them.
    function automatic logic [31:0] addr_to_idx(input logic [63:0] addr,
                                                input int unsigned lsb,
                                                input int unsigned idx_w);
        logic [63:0] mask;
        mask = (64'd1 << idx_w) - 64'd1;
        return 32'((addr >> lsb) & mask);
    endfunction

endpackage

// File: rtl/axil_reg_bridge_if.sv
// AXI4-Lite five-channel bundle; signal suffixes are from the slave's view.
interface axil_reg_bridge_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    localparam int STRB_WIDTH = DATA_WIDTH / 8;

    logic [ADDR_WIDTH-1:0] awaddr_i;
    logic                  awvalid_i;
    logic                  awready_o;
    logic [DATA_WIDTH-1:0] wdata_i;
    logic [STRB_WIDTH-1:0] wstrb_i;
    logic                  wvalid_i;
    logic                  wready_o;
    logic [1:0]            bresp_o;
    logic                  bvalid_o;
    logic                  bready_i;
    logic [ADDR_WIDTH-1:0] araddr_i;
    logic                  arvalid_i;
    logic                  arready_o;
    logic [DATA_WIDTH-1:0] rdata_o;
    logic [1:0]            rresp_o;
    logic                  rvalid_o;
    logic                  rready_i;

    modport slave (
        input  awaddr_i, awvalid_i, wdata_i, wstrb_i, wvalid_i, bready_i,
               araddr_i, arvalid_i, rready_i,
        output awready_o, wready_o, bresp_o, bvalid_o, arready_o,
               rdata_o, rresp_o, rvalid_o
    );

    modport master (
        output awaddr_i, awvalid_i, wdata_i, wstrb_i, wvalid_i, bready_i,
               araddr_i, arvalid_i, rready_i,
        input  awready_o, wready_o, bresp_o, bvalid_o, arready_o,
               rdata_o, rresp_o, rvalid_o
    );

endinterface

// File: rtl/axil_addr_chk.sv
// Combinational word-index extraction and range check for one address path.
// AXIL_ADDR_CHECK_EN flags out-of-range addresses; otherwise the index wraps.
module axil_addr_chk
    import axil_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int REG_COUNT  = 16,
    localparam int unsigned IDX_W = $clog2(REG_COUNT),
    localparam int unsigned LSB   = $clog2(DATA_WIDTH / 8)
) (
    input  logic [ADDR_WIDTH-1:0] addr_i,
    output logic [IDX_W-1:0]      idx_o,
    output logic                  err_o
);

    // Index and error flag straight from the address.
    always_comb begin
        idx_o = IDX_W'(addr_to_idx(64'(addr_i), LSB, IDX_W));
`ifdef AXIL_ADDR_CHECK_EN
        // Full word address compare covers both idx >= REG_COUNT and stray upper bits.
        err_o = (addr_i >> LSB) >= ADDR_WIDTH'(REG_COUNT);
`else
        err_o = 1'b0;
`endif
    end

endmodule

// File: rtl/axil_reg_bridge.sv
// AXI4-Lite slave that turns each transaction into a single-beat register access.
// Optional AXIL_ADDR_CHECK_EN: out-of-range accesses get SLVERR and no strobe.
module axil_reg_bridge
    import axil_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int REG_COUNT  = 16,
    localparam int STRB_WIDTH = DATA_WIDTH / 8,
    localparam int IDX_W      = $clog2(REG_COUNT)
) (
    input  logic                  clk_i,
    input  logic                  rstn_i,
    axil_reg_bridge_if.slave      axil,
    output logic                  reg_wr_en_o,
    output logic [IDX_W-1:0]      reg_wr_idx_o,
    output logic [DATA_WIDTH-1:0] reg_wr_data_o,
    output logic [STRB_WIDTH-1:0] reg_wr_strb_o,
    output logic                  reg_rd_en_o,
    output logic [IDX_W-1:0]      reg_rd_idx_o,
    input  logic [DATA_WIDTH-1:0] reg_rd_data_i
);

    wr_state_t             wr_state_q;
    logic                  awready_q, wready_q, bvalid_q, wr_en_q, wr_err_q;
    axil_resp_t            bresp_q;
    logic [IDX_W-1:0]      wr_idx_q;
    logic [DATA_WIDTH-1:0] wr_data_q;
    logic [STRB_WIDTH-1:0] wr_strb_q;

    rd_state_t             rd_state_q;
    logic                  arready_q, rvalid_q, rd_en_q, rd_err_q, rd_first_q;
    axil_resp_t            rresp_q;
    logic [IDX_W-1:0]      rd_idx_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic [DATA_WIDTH-1:0] rdata_s;

    logic [IDX_W-1:0]      aw_idx_s, ar_idx_s;
    logic                  aw_err_s, ar_err_s;
    logic                  aw_hs_s, w_hs_s, ar_hs_s;

    assign aw_hs_s = axil.awvalid_i & awready_q;
    assign w_hs_s  = axil.wvalid_i & wready_q;
    assign ar_hs_s = axil.arvalid_i & arready_q;

    axil_addr_chk #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH),
        .REG_COUNT  (REG_COUNT)
    ) u_wr_chk (
        .addr_i (axil.awaddr_i),
        .idx_o  (aw_idx_s),
        .err_o  (aw_err_s)
    );

    axil_addr_chk #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH),
        .REG_COUNT  (REG_COUNT)
    ) u_rd_chk (
        .addr_i (axil.araddr_i),
        .idx_o  (ar_idx_s),
        .err_o  (ar_err_s)
    );

    // Write path FSM: independent AW/W acceptance, one-cycle strobe, held response.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            wr_state_q <= WR_IDLE;
            awready_q  <= 1'b0;
            wready_q   <= 1'b0;
            bvalid_q   <= 1'b0;
            bresp_q    <= RESP_OKAY;
            wr_en_q    <= 1'b0;
            wr_err_q   <= 1'b0;
            wr_idx_q   <= '0;
            wr_data_q  <= '0;
            wr_strb_q  <= '0;
        end else begin
            case (wr_state_q)
                WR_IDLE: begin
                    if (aw_hs_s && w_hs_s) begin
                        wr_idx_q   <= aw_idx_s;
                        wr_err_q   <= aw_err_s;
                        wr_data_q  <= axil.wdata_i;
                        wr_strb_q  <= axil.wstrb_i;
                        wr_en_q    <= ~aw_err_s;
                        awready_q  <= 1'b0;
                        wready_q   <= 1'b0;
                        wr_state_q <= WR_EXEC;
                    end else if (aw_hs_s) begin
                        wr_idx_q   <= aw_idx_s;
                        wr_err_q   <= aw_err_s;
                        awready_q  <= 1'b0;
                        wready_q   <= 1'b1;
                        wr_state_q <= WR_GOT_AW;
                    end else if (w_hs_s) begin
                        wr_data_q  <= axil.wdata_i;
                        wr_strb_q  <= axil.wstrb_i;
                        awready_q  <= 1'b1;
                        wready_q   <= 1'b0;
                        wr_state_q <= WR_GOT_W;
                    end else begin
                        awready_q  <= 1'b1;
                        wready_q   <= 1'b1;
                    end
                end
                WR_GOT_AW: begin
                    if (w_hs_s) begin
                        wr_data_q  <= axil.wdata_i;
                        wr_strb_q  <= axil.wstrb_i;
                        wr_en_q    <= ~wr_err_q;
                        wready_q   <= 1'b0;
                        wr_state_q <= WR_EXEC;
                    end
                end
                WR_GOT_W: begin
                    if (aw_hs_s) begin
                        wr_idx_q   <= aw_idx_s;
                        wr_err_q   <= aw_err_s;
                        wr_en_q    <= ~aw_err_s;
                        awready_q  <= 1'b0;
                        wr_state_q <= WR_EXEC;
                    end
                end
                WR_EXEC: begin
                    wr_en_q    <= 1'b0;
                    bvalid_q   <= 1'b1;
                    bresp_q    <= wr_err_q ? RESP_SLVERR : RESP_OKAY;
                    wr_state_q <= WR_RESP;
                end
                WR_RESP: begin
                    if (axil.bready_i) begin
                        bvalid_q   <= 1'b0;
                        awready_q  <= 1'b1;
                        wready_q   <= 1'b1;
                        wr_state_q <= WR_IDLE;
                    end
                end
                default: begin
                    wr_en_q    <= 1'b0;
                    bvalid_q   <= 1'b0;
                    awready_q  <= 1'b0;
                    wready_q   <= 1'b0;
                    wr_state_q <= WR_IDLE;
                end
            endcase
        end
    end

    // Read path FSM: strobe, then capture register data on the first response cycle.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            rd_state_q <= RD_IDLE;
            arready_q  <= 1'b0;
            rvalid_q   <= 1'b0;
            rresp_q    <= RESP_OKAY;
            rd_en_q    <= 1'b0;
            rd_err_q   <= 1'b0;
            rd_first_q <= 1'b0;
            rd_idx_q   <= '0;
            rdata_q    <= '0;
        end else begin
            case (rd_state_q)
                RD_IDLE: begin
                    if (ar_hs_s) begin
                        rd_idx_q   <= ar_idx_s;
                        rd_err_q   <= ar_err_s;
                        rd_en_q    <= ~ar_err_s;
                        arready_q  <= 1'b0;
                        rd_state_q <= RD_EXEC;
                    end else begin
                        arready_q  <= 1'b1;
                    end
                end
                RD_EXEC: begin
                    rd_en_q    <= 1'b0;
                    rvalid_q   <= 1'b1;
                    rd_first_q <= 1'b1;
                    rresp_q    <= rd_err_q ? RESP_SLVERR : RESP_OKAY;
                    rd_state_q <= RD_RESP;
                end
                RD_RESP: begin
                    rd_first_q <= 1'b0;
                    if (rd_first_q) begin
                        rdata_q <= rd_err_q ? '0 : reg_rd_data_i;
                    end
                    if (axil.rready_i) begin
                        rvalid_q   <= 1'b0;
                        arready_q  <= 1'b1;
                        rd_state_q <= RD_IDLE;
                    end
                end
                default: begin
                    rd_en_q    <= 1'b0;
                    rvalid_q   <= 1'b0;
                    rd_first_q <= 1'b0;
                    arready_q  <= 1'b0;
                    rd_state_q <= RD_IDLE;
                end
            endcase
        end
    end

    // Register data arrives in the first response cycle, so pass it through until captured.
    always_comb begin
        if (rd_first_q) begin
            if (rd_err_q) begin
                rdata_s = '0;
            end else begin
                rdata_s = reg_rd_data_i;
            end
        end else begin
            rdata_s = rdata_q;
        end
    end

    assign axil.awready_o = awready_q;
    assign axil.wready_o  = wready_q;
    assign axil.bvalid_o  = bvalid_q;
    assign axil.bresp_o   = bresp_q;
    assign axil.arready_o = arready_q;
    assign axil.rvalid_o  = rvalid_q;
    assign axil.rresp_o   = rresp_q;
    assign axil.rdata_o   = rdata_s;

    assign reg_wr_en_o   = wr_en_q;
    assign reg_wr_idx_o  = wr_idx_q;
    assign reg_wr_data_o = wr_data_q;
    assign reg_wr_strb_o = wr_strb_q;
    assign reg_rd_en_o   = rd_en_q;
    assign reg_rd_idx_o  = rd_idx_q;

endmodule

// File: tb/tb_axil_reg_bridge.sv
// Self-checking bench for axil_reg_bridge: directed scenarios plus randomized
// traffic checked against a word-array reference model.
module tb_axil_reg_bridge;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int RC = 16;
    localparam int SW = DW / 8;
    localparam int IW = $clog2(RC);

    logic clk_i  = 1'b0;
    logic rstn_i = 1'b0;
    always #5 clk_i = ~clk_i;

    axil_reg_bridge_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    logic          reg_wr_en_o;
    logic [IW-1:0] reg_wr_idx_o;
    logic [DW-1:0] reg_wr_data_o;
    logic [SW-1:0] reg_wr_strb_o;
    logic          reg_rd_en_o;
    logic [IW-1:0] reg_rd_idx_o;
    logic [DW-1:0] reg_rd_data_i;

    axil_reg_bridge #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .REG_COUNT(RC)) dut (
        .clk_i         (clk_i),
        .rstn_i        (rstn_i),
        .axil          (bus),
        .reg_wr_en_o   (reg_wr_en_o),
        .reg_wr_idx_o  (reg_wr_idx_o),
        .reg_wr_data_o (reg_wr_data_o),
        .reg_wr_strb_o (reg_wr_strb_o),
        .reg_rd_en_o   (reg_rd_en_o),
        .reg_rd_idx_o  (reg_rd_idx_o),
        .reg_rd_data_i (reg_rd_data_i)
    );

    int checks = 0;
    int errors = 0;

    // Register file behind the bridge: synchronous read-before-write.
    logic [DW-1:0] rf_mem [RC] = '{default: '0};
    logic [DW-1:0] rf_rdata = '0;
    int            wr_cnt = 0;
    assign reg_rd_data_i = rf_rdata;

    always @(posedge clk_i) begin
        if (reg_rd_en_o) rf_rdata <= rf_mem[reg_rd_idx_o];
        if (reg_wr_en_o) begin
            wr_cnt <= wr_cnt + 1;
            for (int b = 0; b < SW; b++)
                if (reg_wr_strb_o[b]) rf_mem[reg_wr_idx_o][8*b +: 8] <= reg_wr_data_o[8*b +: 8];
        end
    end

    wire [86:0] outs_s = {bus.awready_o, bus.wready_o, bus.arready_o, bus.bvalid_o, bus.rvalid_o,
                          reg_wr_en_o, reg_rd_en_o, bus.bresp_o, bus.rresp_o, bus.rdata_o,
                          reg_wr_idx_o, reg_wr_data_o, reg_wr_strb_o, reg_rd_idx_o};

    // Reference model: word array, byte merge, decoding by plain arithmetic.
    logic [DW-1:0] ref_mem [RC];

    function automatic int exp_idx(input logic [31:0] a);
        return int'((a / 32'd4) % 32'd16);
    endfunction

    function automatic bit exp_err(input logic [31:0] a);
`ifdef AXIL_ADDR_CHECK_EN
        return (a / 32'd4) >= 32'd16;
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [1:0] exp_resp(input logic [31:0] a);
        return exp_err(a) ? 2'b10 : 2'b00;
    endfunction

    function automatic logic [31:0] exp_read(input logic [31:0] a);
        return exp_err(a) ? 32'h0 : ref_mem[exp_idx(a)];
    endfunction

    task automatic ref_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        if (!exp_err(a))
            for (int b = 0; b < 4; b++)
                if (s[b]) ref_mem[exp_idx(a)][8*b +: 8] = d[8*b +: 8];
    endtask

    // lead > 0: W goes that many cycles before AW; lead < 0: AW first.
    task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                            input int lead, output logic [1:0] resp, output int lat_en,
                            output int lat_b, output bit to);
        bit aw_done, w_done, aw_hs, w_hs;
        int c, aw_st, w_st;
        aw_done = 1'b0; w_done = 1'b0; c = 0; to = 1'b0;
        resp = 2'b11; lat_en = -1; lat_b = -1;
        aw_st = (lead > 0) ? lead : 0;
        w_st  = (lead < 0) ? -lead : 0;
        bus.awaddr_i = addr; bus.wdata_i = data; bus.wstrb_i = strb;
        while (!(aw_done && w_done) && !to) begin
            bus.awvalid_i = !aw_done && (c >= aw_st);
            bus.wvalid_i  = !w_done && (c >= w_st);
            @(negedge clk_i);
            aw_hs = bus.awvalid_i && bus.awready_o;
            w_hs  = bus.wvalid_i && bus.wready_o;
            @(posedge clk_i); #1;
            aw_done |= aw_hs; w_done |= w_hs; c++;
            if (c > 50) to = 1'b1;
        end
        bus.awvalid_i = 1'b0; bus.wvalid_i = 1'b0;
        for (int k = 1; k <= 20 && !to && lat_b < 0; k++) begin
            @(negedge clk_i);
            if (reg_wr_en_o && lat_en < 0) lat_en = k;
            if (bus.bvalid_o) begin
                lat_b = k; resp = bus.bresp_o;
            end else begin
                @(posedge clk_i); #1;
            end
        end
        if (!to && lat_b < 0) to = 1'b1;
        if (!to) begin
            bus.bready_i = 1'b1; @(posedge clk_i); #1; bus.bready_i = 1'b0;
        end
    endtask

    task automatic do_read(input logic [31:0] addr, input int stall, output logic [31:0] data,
                           output logic [1:0] resp, output int lat_en, output int lat_r,
                           output bit held_ok, output bit to);
        bit hs;
        int c;
        hs = 1'b0; c = 0; to = 1'b0; held_ok = 1'b1;
        data = 32'hX; resp = 2'b11; lat_en = -1; lat_r = -1;
        bus.araddr_i = addr;
        while (!hs && !to) begin
            bus.arvalid_i = 1'b1;
            @(negedge clk_i);
            hs = bus.arready_o;
            @(posedge clk_i); #1;
            c++;
            if (c > 50) to = 1'b1;
        end
        bus.arvalid_i = 1'b0;
        for (int k = 1; k <= 20 && !to && lat_r < 0; k++) begin
            @(negedge clk_i);
            if (reg_rd_en_o && lat_en < 0) lat_en = k;
            if (bus.rvalid_o) begin
                lat_r = k; data = bus.rdata_o; resp = bus.rresp_o;
            end else begin
                @(posedge clk_i); #1;
            end
        end
        if (!to && lat_r < 0) to = 1'b1;
        if (!to) begin
            for (int s = 0; s < stall; s++) begin
                @(posedge clk_i); @(negedge clk_i);
                if (!bus.rvalid_o || bus.rdata_o !== data || bus.rresp_o !== resp || bus.arready_o)
                    held_ok = 1'b0;
            end
            bus.rready_i = 1'b1; @(posedge clk_i); #1; bus.rready_i = 1'b0;
        end
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        checks++;
        if (outs_s !== 87'd0) begin
            errors++; $display("FAIL reset_outputs: got %h expected 0", outs_s);
        end
        rstn_i = 1'b1; #1;
        checks++;
        if ({bus.awready_o, bus.wready_o, bus.arready_o} !== 3'b000) begin
            errors++; $display("FAIL ready_before_edge: got %b expected 000",
                               {bus.awready_o, bus.wready_o, bus.arready_o});
        end
        @(posedge clk_i); #1;
        checks++;
        if ({bus.awready_o, bus.wready_o, bus.arready_o} !== 3'b111) begin
            errors++; $display("FAIL ready_after_release: got %b expected 111",
                               {bus.awready_o, bus.wready_o, bus.arready_o});
        end
    endtask

    task automatic test_write_same_cycle();
        bus.awaddr_i = 32'h08; bus.awvalid_i = 1'b1;
        bus.wdata_i = 32'hDEADBEEF; bus.wstrb_i = 4'hF; bus.wvalid_i = 1'b1;
        @(posedge clk_i); #1;
        bus.awvalid_i = 1'b0; bus.wvalid_i = 1'b0;
        checks++;
        if ({reg_wr_en_o, reg_wr_idx_o, reg_wr_data_o, reg_wr_strb_o, bus.bvalid_o} !==
            {1'b1, 4'd2, 32'hDEADBEEF, 4'hF, 1'b0}) begin
            errors++; $display("FAIL same_cycle_strobe: got en=%b idx=%0d data=%h strb=%h bvalid=%b expected 1/2/deadbeef/f/0",
                               reg_wr_en_o, reg_wr_idx_o, reg_wr_data_o, reg_wr_strb_o, bus.bvalid_o);
        end
        @(posedge clk_i); #1;
        checks++;
        if ({reg_wr_en_o, bus.bvalid_o, bus.bresp_o} !== 4'b0100) begin
            errors++; $display("FAIL same_cycle_bresp: got en=%b bvalid=%b bresp=%b expected 0/1/00",
                               reg_wr_en_o, bus.bvalid_o, bus.bresp_o);
        end
        bus.bready_i = 1'b1; @(posedge clk_i); #1; bus.bready_i = 1'b0;
        ref_write(32'h08, 32'hDEADBEEF, 4'hF);
    endtask

    task automatic test_w_before_aw();
        int c0;
        c0 = wr_cnt;
        bus.wdata_i = 32'hA5A55A5A; bus.wstrb_i = 4'b0011; bus.wvalid_i = 1'b1;
        @(posedge clk_i); #1;
        bus.wvalid_i = 1'b0;
        for (int i = 0; i < 2; i++) begin
            checks++;
            if ({bus.wready_o, bus.awready_o} !== 2'b01) begin
                errors++; $display("FAIL w_first_readies: got w=%b aw=%b expected 0/1", bus.wready_o, bus.awready_o);
            end
            if (i == 0) begin @(posedge clk_i); #1; end
        end
        bus.awaddr_i = 32'h04; bus.awvalid_i = 1'b1;
        @(posedge clk_i); #1;
        bus.awvalid_i = 1'b0;
        checks++;
        if ({reg_wr_en_o, reg_wr_idx_o, reg_wr_strb_o, reg_wr_data_o} !== {1'b1, 4'd1, 4'b0011, 32'hA5A55A5A}) begin
            errors++; $display("FAIL w_first_strobe: got en=%b idx=%0d strb=%b data=%h expected 1/1/0011/a5a55a5a",
                               reg_wr_en_o, reg_wr_idx_o, reg_wr_strb_o, reg_wr_data_o);
        end
        @(posedge clk_i); #1;
        bus.bready_i = 1'b1; @(posedge clk_i); #1; bus.bready_i = 1'b0;
        checks++;
        if (wr_cnt - c0 != 1) begin
            errors++; $display("FAIL w_first_strobe_count: got %0d expected 1", wr_cnt - c0);
        end
        ref_write(32'h04, 32'hA5A55A5A, 4'b0011);
    endtask

    task automatic test_read_stall();
        logic [1:0] r; logic [31:0] d; int le, lb; bit to, held;
        do_write(32'h0C, 32'h00001234, 4'hF, 0, r, le, lb, to);
        ref_write(32'h0C, 32'h00001234, 4'hF);
        do_read(32'h0C, 5, d, r, le, lb, held, to);
        checks++;
        if (to || d !== 32'h00001234 || r !== 2'b00) begin
            errors++; $display("FAIL read_stall_data: got to=%b data=%h resp=%b expected 0/00001234/00", to, d, r);
        end
        checks++;
        if (le != 1 || lb != 2) begin
            errors++; $display("FAIL read_latency: got en=%0d rvalid=%0d expected 1/2", le, lb);
        end
        checks++;
        if (!held) begin
            errors++; $display("FAIL read_stall_hold: got held=%b expected 1", held);
        end
        checks++;
        if (bus.arready_o !== 1'b1) begin
            errors++; $display("FAIL read_arready_after: got %b expected 1", bus.arready_o);
        end
    endtask

    task automatic test_addr_range();
        logic [31:0] addrs [2];
        logic [1:0] r; logic [31:0] d, wd; int le, lb; bit to, held;
        addrs[0] = 32'h00000040; addrs[1] = 32'h80000014;
        for (int i = 0; i < 2; i++) begin
            wd = $urandom;
            do_write(addrs[i], wd, 4'hF, 0, r, le, lb, to);
            checks++;
            if (to || r !== exp_resp(addrs[i]) || le != (exp_err(addrs[i]) ? -1 : 1)) begin
                errors++; $display("FAIL range_write %h: got to=%b resp=%b en_lat=%0d expected resp=%b", addrs[i], to, r, le, exp_resp(addrs[i]));
            end
            ref_write(addrs[i], wd, 4'hF);
            do_read(addrs[i], 0, d, r, le, lb, held, to);
            checks++;
            if (to || d !== exp_read(addrs[i]) || r !== exp_resp(addrs[i]) || le != (exp_err(addrs[i]) ? -1 : 1)) begin
                errors++; $display("FAIL range_read %h: got data=%h resp=%b en_lat=%0d expected %h/%b",
                                   addrs[i], d, r, le, exp_read(addrs[i]), exp_resp(addrs[i]));
            end
        end
    endtask

    task automatic test_zero_strb();
        logic [1:0] r; logic [31:0] d; int le, lb; bit to, held;
        do_write(32'h14, 32'hFFFFFFFF, 4'h0, 0, r, le, lb, to);
        checks++;
        if (to || r !== 2'b00 || le != 1 || lb != 2) begin
            errors++; $display("FAIL zero_strb_write: got to=%b resp=%b en=%0d b=%0d expected 0/00/1/2", to, r, le, lb);
        end
        do_read(32'h14, 0, d, r, le, lb, held, to);
        checks++;
        if (d !== exp_read(32'h14)) begin
            errors++; $display("FAIL zero_strb_read: got %h expected %h", d, exp_read(32'h14));
        end
    endtask

    task automatic test_concurrent();
        logic [1:0] r; logic [31:0] d, old; int le, lb; bit to, held;
        do_write(32'h0C, 32'hCAFE0001, 4'hF, 0, r, le, lb, to);
        ref_write(32'h0C, 32'hCAFE0001, 4'hF);
        old = ref_mem[3];
        bus.awaddr_i = 32'h0C; bus.awvalid_i = 1'b1;
        bus.wdata_i = 32'h0BADF00D; bus.wstrb_i = 4'hF; bus.wvalid_i = 1'b1;
        bus.araddr_i = 32'h0C; bus.arvalid_i = 1'b1;
        @(posedge clk_i); #1;
        bus.awvalid_i = 1'b0; bus.wvalid_i = 1'b0; bus.arvalid_i = 1'b0;
        checks++;
        if ({reg_wr_en_o, reg_rd_en_o, reg_wr_idx_o, reg_rd_idx_o} !== {1'b1, 1'b1, 4'd3, 4'd3}) begin
            errors++; $display("FAIL concurrent_strobes: got wr=%b rd=%b widx=%0d ridx=%0d expected 1/1/3/3",
                               reg_wr_en_o, reg_rd_en_o, reg_wr_idx_o, reg_rd_idx_o);
        end
        @(posedge clk_i); #1;
        checks++;
        if ({bus.bvalid_o, bus.rvalid_o} !== 2'b11 || bus.rdata_o !== old) begin
            errors++; $display("FAIL concurrent_old_value: got bv=%b rv=%b data=%h expected 1/1/%h",
                               bus.bvalid_o, bus.rvalid_o, bus.rdata_o, old);
        end
        bus.bready_i = 1'b1; bus.rready_i = 1'b1;
        @(posedge clk_i); #1;
        bus.bready_i = 1'b0; bus.rready_i = 1'b0;
        ref_write(32'h0C, 32'h0BADF00D, 4'hF);
        do_read(32'h0C, 0, d, r, le, lb, held, to);
        checks++;
        if (d !== exp_read(32'h0C)) begin
            errors++; $display("FAIL concurrent_new_value: got %h expected %h", d, exp_read(32'h0C));
        end
    endtask

    task automatic test_reset_mid();
        logic [1:0] r; logic [31:0] d, wd; int le, lb, c0; bit to, held;
        c0 = wr_cnt;
        bus.awaddr_i = 32'h10; bus.awvalid_i = 1'b1;
        @(posedge clk_i); #1;
        bus.awvalid_i = 1'b0;
        checks++;
        if ({bus.awready_o, bus.wready_o} !== 2'b01) begin
            errors++; $display("FAIL mid_got_aw: got aw=%b w=%b expected 0/1", bus.awready_o, bus.wready_o);
        end
        @(negedge clk_i);
        rstn_i = 1'b0; #1;
        checks++;
        if (outs_s !== 87'd0) begin
            errors++; $display("FAIL mid_reset_outputs: got %h expected 0", outs_s);
        end
        bus.wdata_i = 32'h11112222; bus.wstrb_i = 4'hF; bus.wvalid_i = 1'b1;
        repeat (2) @(posedge clk_i);
        #1; bus.wvalid_i = 1'b0;
        @(negedge clk_i); rstn_i = 1'b1;
        @(posedge clk_i); #1;
        checks++;
        if (wr_cnt != c0) begin
            errors++; $display("FAIL mid_reset_no_strobe: got %0d strobes expected 0", wr_cnt - c0);
        end
        wd = $urandom;
        do_write(32'h10, wd, 4'hF, -1, r, le, lb, to);
        checks++;
        if (to || r !== 2'b00 || le != 1 || lb != 2) begin
            errors++; $display("FAIL mid_reset_recover: got to=%b resp=%b en=%0d b=%0d expected 0/00/1/2", to, r, le, lb);
        end
        ref_write(32'h10, wd, 4'hF);
        do_read(32'h10, 0, d, r, le, lb, held, to);
        checks++;
        if (d !== exp_read(32'h10)) begin
            errors++; $display("FAIL mid_reset_readback: got %h expected %h", d, exp_read(32'h10));
        end
    endtask

    task automatic test_random();
        logic [1:0] r; logic [31:0] a, d, wd; logic [3:0] s; int le, lb, st; bit to, held;
        for (int i = 0; i < 30; i++) begin
            if ($urandom_range(0, 7) == 0) a = $urandom;
            else a = 32'($urandom_range(0, 15)) * 32'd4 + 32'($urandom_range(0, 3));
            wd = $urandom; s = 4'($urandom_range(0, 15));
            do_write(a, wd, s, $urandom_range(0, 4) - 2, r, le, lb, to);
            checks++;
            if (to || r !== exp_resp(a) || le != (exp_err(a) ? -1 : 1) || lb != 2) begin
                errors++; $display("FAIL rand_write %h: got to=%b resp=%b en=%0d b=%0d expected resp=%b",
                                   a, to, r, le, lb, exp_resp(a));
            end
            ref_write(a, wd, s);
        end
        for (int i = 0; i < RC; i++) begin
            a = 32'(i) * 32'd4 + 32'($urandom_range(0, 3));
            st = $urandom_range(0, 2);
            do_read(a, st, d, r, le, lb, held, to);
            checks++;
            if (to || d !== exp_read(a) || r !== exp_resp(a) || !held || lb != 2) begin
                errors++; $display("FAIL rand_read %h: got data=%h resp=%b held=%b lat=%0d expected %h/%b",
                                   a, d, r, held, lb, exp_read(a), exp_resp(a));
            end
        end
    endtask

    initial begin
        bus.awaddr_i = '0; bus.awvalid_i = 1'b0; bus.wdata_i = '0; bus.wstrb_i = '0;
        bus.wvalid_i = 1'b0; bus.bready_i = 1'b0; bus.araddr_i = '0; bus.arvalid_i = 1'b0;
        bus.rready_i = 1'b0;
        for (int i = 0; i < RC; i++) ref_mem[i] = '0;
        test_reset();
        test_write_same_cycle();
        test_w_before_aw();
        test_read_stall();
        test_addr_range();
        test_zero_strb();
        test_concurrent();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/axil_reg_bridge.md
Name: axil_reg_bridge

Overview:
- AXI4-Lite slave endpoint: terminates the five AXI4-Lite channels and converts each transaction into a single-beat access on a simple register port.
- Sits between the interconnect and the timer register files.
- Successor to the bare AXI-Lite signal bundle, with:
  - parametrised data width and register count
  - full 2-bit responses
  - byte strobes
  - independent AW/W acceptance
  - out-of-range error handling

Parameters:
- ADDR_WIDTH, 32, AXI address width.
- DATA_WIDTH, 32, data width; must be 32 or 64.
- REG_COUNT, 16, number of word-addressed registers; must be ≥2.
- STRB_WIDTH, DATA_WIDTH/8, derived; not overridable.

Ports:
- clk_i  in  1  clock
- rstn_i  in  1  asynchronous active-low reset
- awaddr_i  in  ADDR_WIDTH;  awvalid_i in 1;  awready_o out 1
- wdata_i  in  DATA_WIDTH;  wstrb_i in STRB_WIDTH;  wvalid_i in 1;  wready_o out 1
- bresp_o  out  2;  bvalid_o out 1;  bready_i in 1
- araddr_i  in  ADDR_WIDTH;  arvalid_i in 1;  arready_o out 1
- rdata_o  out  DATA_WIDTH;  rresp_o out 2;  rvalid_o out 1;  rready_i in 1
- reg_wr_en_o  out  1  one-cycle write strobe
- reg_wr_idx_o  out  $clog2(REG_COUNT)  word index
- reg_wr_data_o  out  DATA_WIDTH
- reg_wr_strb_o  out  STRB_WIDTH
- reg_rd_en_o  out  1  one-cycle read strobe
- reg_rd_idx_o  out  $clog2(REG_COUNT)
- reg_rd_data_i  in  DATA_WIDTH  valid the cycle after reg_rd_en_o

Behaviour:
- One clock, clk_i; reset is asynchronous and active-low on rstn_i.
- Reset values:
  - All valids, readies and strobes 0.
  - bresp_o, rresp_o, rdata_o, idx/data/strb outputs 0.
  - awready_o/wready_o/arready_o rise the first cycle after reset release.
- Word index = addr[$clog2(STRB_WIDTH) +: $clog2(REG_COUNT)]. Low address bits are ignored (no misalignment error).
- Write FSM, states WR_IDLE, WR_GOT_AW, WR_GOT_W, WR_EXEC, WR_RESP:
  - WR_IDLE:
    - awready_o=wready_o=1.
    - AW+W in the same cycle -> WR_EXEC.
    - AW only -> WR_GOT_AW (awready_o drops, wready_o stays 1).
    - W only -> WR_GOT_W (symmetric).
  - WR_GOT_AW / WR_GOT_W: the missing handshake -> WR_EXEC.
  - WR_EXEC (1 cycle): reg_wr_en_o=1 with the latched idx/data/strb, unless the access is in error. -> WR_RESP.
  - WR_RESP: bvalid_o=1; bresp_o held stable until bready_i. Then -> WR_IDLE.
  - Latency: handshake in cycle N -> reg_wr_en_o in N+1 -> bvalid_o in N+2.
  - wstrb_i==0 is legal: strobe pulses with strb 0, OKAY response.
- Read FSM, states RD_IDLE, RD_EXEC, RD_RESP:
  - RD_IDLE: arready_o=1; AR handshake -> RD_EXEC.
  - RD_EXEC: reg_rd_en_o=1 (suppressed on error); capture reg_rd_data_i next cycle. -> RD_RESP.
  - RD_RESP: rvalid_o=1 with rdata/rresp held until rready_i. Then -> RD_IDLE.
  - Latency: AR in N -> reg_rd_en_o in N+1 -> rvalid_o in N+2.
- Read and write FSMs are fully independent.
  - Simultaneous read and write to the same index: read returns the pre-write value when reg_rd_en_o and reg_wr_en_o coincide; the register file guarantees read-before-write.
- Back-pressure: bvalid_o/rvalid_o stalled indefinitely by the master. No new transaction is accepted on that path meanwhile (readies 0).
- Responses: OKAY=2'b00, SLVERR=2'b10. Without the optional feature, always OKAY.
- Reset mid-transaction: FSMs return to idle, in-flight transaction discarded, no strobe emitted.

Optional Feature:
- AXIL_ADDR_CHECK_EN defined:
  - Write with word index ≥ REG_COUNT, or any address bits above the index field nonzero: reg_wr_en_o suppressed, bresp_o=SLVERR.
  - Read under the same condition: reg_rd_en_o suppressed, rdata_o=0, rresp_o=SLVERR.
- Undefined: upper bits ignored, index wraps modulo 2^$clog2(REG_COUNT), always OKAY.

Decomposition:
- Package axil_pkg:
  - typedef axil_resp_t (2-bit)
  - constants RESP_OKAY, RESP_SLVERR
  - enum wr_state_t, enum rd_state_t
  - function addr_to_idx
- One natural sub-module, axil_addr_chk: combinational index extraction and range check, instanced once per path.

Test Plan:
- Same-cycle AW/W to addr 0x08, wdata 0xDEADBEEF, strb 4'hF -> reg_wr_en_o at N+1 with idx 2; bvalid_o at N+2 with bresp 00.
- W two cycles before AW, addr 0x04, strb 4'b0011 -> wready_o low after W; reg_wr_idx_o=1, reg_wr_strb_o=0011; single strobe.
- Read addr 0x0C, reg_rd_data_i=0x1234 one cycle after strobe; rready_i low 5 cycles -> rvalid_o/rdata_o=0x1234 held stable; arready_o 0 until accepted.
- With AXIL_ADDR_CHECK_EN, REG_COUNT=16: write to 0x40 -> no reg_wr_en_o, bresp 10; read 0x40 -> rdata 0, rresp 10. Without it: write hits idx 0, OKAY.
- Concurrent write and read to idx 3 in the same cycle -> both strobes in N+1; read returns the old value.
- rstn_i asserted while in WR_GOT_AW -> no reg_wr_en_o, all outputs at reset values; after release, a new write completes normally.
